// File: rtl/alu_exec_unit.sv
// Multi-cycle RISC-V integer execute unit with valid/ready on both sides.
// Define ALU_FAST_SHIFT_EN to replace the bit-serial shifter with a barrel shifter.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST_SHIFT = 1'b1;
`else
    localparam bit FAST_SHIFT = 1'b0;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [SW-1:0]    cnt;
    logic [1:0]       sh_op;
    logic [SW-1:0]    shamt;
    logic             is_shift;
    logic [WIDTH-1:0] calc_res;
    logic             calc_taken;
    logic [WIDTH-1:0] shift_next;

    assign shamt     = op_b[SW-1:0];
    assign is_shift  = (alu_ctrl == 4'b1000) || (alu_ctrl == 4'b1010) || (alu_ctrl == 4'b1011);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Single-cycle result for everything except a multi-cycle shift.
    always_comb begin
        calc_res   = '0;
        calc_taken = 1'b0;
        case (alu_ctrl)
            4'b0000: calc_res = op_a & op_b;
            4'b0001: calc_res = op_a | op_b;
            4'b0010: calc_res = op_a + op_b;
            4'b0011: calc_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            4'b0100: calc_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b0101: calc_taken = op_a < op_b;
            4'b0110: calc_res = op_a - op_b;
            4'b0111: calc_taken = op_a >= op_b;
            4'b1001: calc_res = op_a ^ op_b;
            4'b1100: calc_taken = op_a == op_b;
            4'b1101: calc_taken = op_a != op_b;
            4'b1110: calc_taken = $signed(op_a) < $signed(op_b);
            4'b1111: calc_taken = $signed(op_a) >= $signed(op_b);
`ifdef ALU_FAST_SHIFT_EN
            4'b1000: calc_res = op_a << shamt;
            4'b1010: calc_res = op_a >> shamt;
            4'b1011: calc_res = $signed(op_a) >>> shamt;
`else
            // Only reached with shamt == 0 in this build.
            4'b1000, 4'b1010, 4'b1011: calc_res = op_a;
`endif
            default: ;
        endcase
        // Branch codes leave calc_res at zero, so the taken bit becomes the result.
        if (calc_taken) calc_res = {{(WIDTH-1){1'b0}}, 1'b1};
    end

    // sh_op holds alu_ctrl[1:0]: 00 SLL, 10 SRL, 11 SRA.
    always_comb begin
        case (sh_op)
            2'b00:   shift_next = {acc[WIDTH-2:0], 1'b0};
            2'b10:   shift_next = {1'b0, acc[WIDTH-1:1]};
            2'b11:   shift_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: shift_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            acc          <= '0;
            cnt          <= '0;
            sh_op        <= 2'b00;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!FAST_SHIFT && is_shift && shamt != '0) begin
                            acc   <= op_a;
                            cnt   <= shamt;
                            sh_op <= alu_ctrl[1:0];
                            state <= S_SHIFT;
                        end else begin
                            result       <= calc_res;
                            zero         <= (calc_res == '0);
                            branch_taken <= calc_taken;
                            state        <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= shift_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == SW'(1)) begin
                        result       <= shift_next;
                        zero         <= (shift_next == '0);
                        branch_taken <= 1'b0;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
